// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM capture front end.
package pdm_pkg;

  localparam int PCM_W = 16;

  typedef struct packed {
    logic signed [PCM_W-1:0] left;
    logic signed [PCM_W-1:0] right;
  } pcm_frame_t;

  function automatic int acc_w(input int order, input int decim);
    return order * $clog2(decim) + 1;
  endfunction

  // pos_full flags the one code that aliases +DECIM^ORDER onto the most negative value.
  function automatic logic signed [31:0] cic_scale(input logic signed [63:0] v,
                                                   input int shift,
                                                   input int out_w,
                                                   input logic pos_full);
    logic signed [63:0] s, hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    s  = v >>> shift;
    if (pos_full || s > hi) s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction

endpackage

// File: rtl/pdm_cic_capture_cic_decimator.sv
// One channel of CIC decimation: direct-form integrators at the bit rate, combs at the frame rate.
module cic_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM = 64,
  parameter int ORDER = 3,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             pdm_bit,
  input  logic             dump_en,
  output logic [OUT_W-1:0] pcm
);

  localparam int ACC_W = acc_w(ORDER, DECIM);

  logic [ORDER-1:0][ACC_W-1:0] integ_q, integ_d, dly_q, comb_in;
  logic signed [ACC_W-1:0]     acc_i, acc_c, comb_out;
  logic                        last_bit, pos_full;

  always_comb begin
    integ_d = integ_q;
    comb_in = '0;
    acc_i   = pdm_bit ? ACC_W'(1) : '1;
    for (int k = 0; k < ORDER; k++) begin
      acc_i      = integ_q[k] + acc_i;
      integ_d[k] = acc_i;
    end
    acc_c = integ_q[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = acc_c;
      acc_c      = acc_c - dly_q[k];
    end
    comb_out = acc_c;
  end

  // A full-scale result spans only identical bits, so the newest integrated bit gives its sign.
  assign pos_full = last_bit && (comb_out == {1'b1, {(ACC_W-1){1'b0}}});
  assign pcm      = OUT_W'(cic_scale(64'(comb_out), ACC_W - OUT_W, OUT_W, pos_full));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ_q  <= '0;
      dly_q    <= '0;
      last_bit <= 1'b0;
    end else begin
      if (sample_en) begin
        integ_q  <= integ_d;
        last_bit <= pdm_bit;
      end
      if (dump_en) dly_q <= comb_in;
    end
  end

endmodule

// File: rtl/pdm_cic_capture.sv
// PDM mic front end: bit clock, L/R capture, CIC decimation, valid/ready output with sticky overflow.
// Define PDM_CIC_CAPTURE_STEREO_EN to build the right-channel filter; otherwise out_right stays 0.
module pdm_cic_capture
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 36,
  parameter int DECIM   = 64,
  parameter int ORDER   = 3,
  parameter int OUT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pdm_clk,
  input  logic             pdm_data,
  output logic [OUT_W-1:0] out_left,
  output logic [OUT_W-1:0] out_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int FRM_W = $clog2(DECIM);

  logic [CNT_W-1:0] cnt;
  logic [FRM_W-1:0] frm_cnt;
  logic             sync1, sync2, bit_q, left_en, right_en;
  logic             frame_end, drop;
  logic [OUT_W-1:0] pcm_l, pcm_r;

  assign frame_end = right_en && (frm_cnt == '1);
  assign drop      = frame_end && out_valid && !out_ready;

  cic_decimator #(.DECIM(DECIM), .ORDER(ORDER), .OUT_W(OUT_W)) u_left (
    .clk(clk), .rst_n(rst_n), .sample_en(left_en), .pdm_bit(bit_q),
    .dump_en(frame_end), .pcm(pcm_l)
  );

`ifdef PDM_CIC_CAPTURE_STEREO_EN
  cic_decimator #(.DECIM(DECIM), .ORDER(ORDER), .OUT_W(OUT_W)) u_right (
    .clk(clk), .rst_n(rst_n), .sample_en(right_en), .pdm_bit(bit_q),
    .dump_en(frame_end), .pcm(pcm_r)
  );
`else
  assign pcm_r = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      pdm_clk   <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      bit_q     <= 1'b0;
      left_en   <= 1'b0;
      right_en  <= 1'b0;
      frm_cnt   <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      cnt      <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
      pdm_clk  <= (cnt < CNT_W'(HALF));
      sync1    <= pdm_data;
      sync2    <= sync1;
      left_en  <= (cnt == CNT_W'(HALF - 1));
      right_en <= (cnt == CNT_W'(CLK_DIV - 1));
      if (cnt == CNT_W'(HALF - 1) || cnt == CNT_W'(CLK_DIV - 1)) bit_q <= sync2;
      if (right_en) frm_cnt <= frm_cnt + 1'b1;

      if (frame_end && !drop) begin
        out_left  <= pcm_l;
        out_right <= pcm_r;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready && !frame_end) begin
        out_valid <= 1'b0;
      end

      if (drop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_cic_capture.sv
// Scoreboard bench for pdm_cic_capture: directed pin patterns, overflow and mid-frame reset.
module tb_pdm_cic_capture;

  localparam int CLK_DIV = 36;
  localparam int DECIM   = 64;
  localparam int ORDER   = 3;
  localparam int OUT_W   = 16;
  localparam int FRAME   = DECIM * CLK_DIV;
`ifdef PDM_CIC_CAPTURE_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, pdm_data = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic pdm_clk, out_valid, ovf;
  logic [OUT_W-1:0] out_left, out_right;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        chk;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0;
  int   mode = 0;
  logic static_bit = 1'b0, lbit = 1'b0, pclk_prev = 1'b0;

  pdm_cic_capture #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .ORDER(ORDER), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pdm_clk(pdm_clk), .pdm_data(pdm_data),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] er(input logic [15:0] v);
    return STEREO ? v : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pin model: mode 0 static, 1 line follows pdm_clk (L=1,R=0), 2 left alternates per period, right=1.
  always @(negedge clk) begin
    case (mode)
      1: pdm_data = pdm_clk;
      2: begin
        if (pdm_clk && !pclk_prev) lbit = ~lbit;
        pdm_data = pdm_clk ? lbit : 1'b1;
      end
      default: pdm_data = static_bit;
    endcase
    pclk_prev = pdm_clk;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame left=%0h right=%0h expected=none", out_left, out_right);
      end else begin
        e = sbq.pop_front();
        if (e.chk) begin
          check("frame_left", 32'(out_left), 32'(e.l));
          check("frame_right", 32'(out_right), 32'(e.r));
        end
      end
    end
  end

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout remaining=%0d expected=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic run_frames(input int m, input logic sb, input int nfr,
                            input logic [15:0] el, input logic [15:0] erv);
    mode       = m;
    static_bit = sb;
    lbit       = 1'b0;
    out_ready  = 1'b1;
    do_reset();
    for (int i = 1; i <= nfr; i++) sbq.push_back('{l: el, r: er(erv), chk: (i >= ORDER)});
    wait_drain(nfr * FRAME + 100);
  endtask

  task automatic wait_signal_valid(input string name, input int limit);
    int n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    if (!out_valid) check(name, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int last_rise, high_cnt, n;
    logic prev;

    rst_n      = 1'b0;
    static_bit = 1'b0;
    out_ready  = 1'b1;
    repeat (4) tick();
    check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out_left", 32'(out_left), 32'd0);
    check("rst_out_right", 32'(out_right), 32'd0);

    rst_n = 1'b1;
    tick();
    check("pdm_clk_first_cycle", 32'(pdm_clk), 32'd1);
    last_rise = 1;
    high_cnt  = 1;
    prev      = pdm_clk;
    for (int cyc = 2; cyc <= 1 + 3 * CLK_DIV; cyc++) begin
      tick();
      if (pdm_clk && !prev) begin
        check("pdm_period", 32'(cyc - last_rise), 32'(CLK_DIV));
        check("pdm_high", 32'(high_cnt), 32'(CLK_DIV / 2));
        last_rise = cyc;
        high_cnt  = 0;
      end
      if (pdm_clk) high_cnt++;
      prev = pdm_clk;
    end

    run_frames(0, 1'b1, 4, 16'h7FFF, 16'h7FFF);
    run_frames(0, 1'b0, 4, 16'h8000, 16'h8000);
    run_frames(1, 1'b0, 4, 16'h7FFF, 16'h8000);
    run_frames(2, 1'b0, 4, 16'h0000, 16'h7FFF);

    // Overflow: settle on all-ones, then stall the consumer across two frame ends.
    mode       = 0;
    static_bit = 1'b1;
    out_ready  = 1'b1;
    do_reset();
    for (int i = 1; i <= 3; i++) sbq.push_back('{l: 16'h7FFF, r: er(16'h7FFF), chk: (i >= ORDER)});
    wait_drain(3 * FRAME + 100);
    out_ready = 1'b0;
    wait_signal_valid("held_frame_timeout", FRAME + 100);
    check("held_left", 32'(out_left), 32'h7FFF);
    static_bit = 1'b0;
    repeat (FRAME + 20) tick();
    check("drop_ovf", 32'(ovf), 32'd1);
    check("drop_valid", 32'(out_valid), 32'd1);
    check("drop_held_left", 32'(out_left), 32'h7FFF);
    check("drop_held_right", 32'(out_right), 32'(er(16'h7FFF)));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    sbq.push_back('{l: 16'h7FFF, r: er(16'h7FFF), chk: 1'b1});
    out_ready = 1'b1;
    tick();
    check("accept_valid_drop", 32'(out_valid), 32'd0);
    wait_drain(5);

    // Mid-frame reset with a held frame and ovf set.
    out_ready  = 1'b0;
    static_bit = 1'b1;
    wait_signal_valid("second_hold_timeout", FRAME + 100);
    n = 0;
    while (!ovf && n < FRAME + 100) begin
      tick();
      n++;
    end
    check("pre_reset_ovf", 32'(ovf), 32'd1);
    repeat (500) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_left", 32'(out_left), 32'd0);
    check("midrst_right", 32'(out_right), 32'd0);
    tick();
    out_ready = 1'b1;
    sbq.push_back('{l: 16'h0, r: 16'h0, chk: 1'b0});
    rst_n = 1'b1;
    n = 0;
    while (!out_valid && n < FRAME + 50) begin
      tick();
      n++;
    end
    checks++;
    if (n < FRAME || n > FRAME + 2) begin
      failures++;
      $display("FAIL first_frame_latency actual=%0d expected=%0d..%0d", n, FRAME, FRAME + 2);
    end
    wait_drain(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
